// File: rtl/teletext_feeder.sv
// rtl/teletext_feeder.sv - teletext timing enables, screen address map and aligned data/control pipe
module teletext_feeder #(
  parameter int         DIV  = 4,
  parameter int         SKEW = 0,
  parameter logic [4:0] BASE = 5'h1F
) (
  input  logic        CLK,
  input  logic        nRESET,
  input  logic        DISPEN,
  input  logic        HSYNC_IN,
  input  logic        VSYNC_IN,
  input  logic        CURSOR_IN,
  input  logic [9:0]  MA,
  input  logic [7:0]  RAM_DATA,
  output logic        CRTC_EN,
  output logic        SA_F1,
  output logic        SA_T6,
  output logic [14:0] VADDR,
  output logic [6:0]  DATABUS,
  output logic        LOSE,
  output logic        HSYNC,
  output logic        VSYNC,
  output logic        CURSOR
);

  localparam logic [3:0] CLK_LAST = 4'(DIV - 1);
  localparam int         DEPTH    = 2 + SKEW;

  logic [3:0] clk_cnt;
  logic [2:0] dot_cnt;
  logic       tick;
  logic [3:0] pipe [DEPTH];
  logic       unused_bit7;

  assign unused_bit7 = RAM_DATA[7];
  assign tick        = (clk_cnt == CLK_LAST);

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      clk_cnt <= 4'd0;
      dot_cnt <= 3'd0;
    end else if (tick) begin
      clk_cnt <= 4'd0;
      dot_cnt <= (dot_cnt == 3'd5) ? 3'd0 : dot_cnt + 3'd1;
    end else begin
      clk_cnt <= clk_cnt + 4'd1;
    end
  end

  // Last dot of the slot loads the next character; the other five shift.
  assign SA_F1   = tick && (dot_cnt == 3'd5);
  assign SA_T6   = tick && (dot_cnt != 3'd5);
  assign CRTC_EN = SA_F1;

  // pipe[0] shares the VADDR edge, so pipe[0][3] qualifies the byte read for that address.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= 4'd0;
      VADDR   <= 15'd0;
      DATABUS <= 7'h20;
    end else if (SA_F1) begin
      pipe[0] <= {DISPEN, HSYNC_IN, VSYNC_IN, CURSOR_IN};
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
      VADDR   <= {BASE, MA};
      DATABUS <= pipe[0][3] ? RAM_DATA[6:0] : 7'h20;
    end
  end

  assign {LOSE, HSYNC, VSYNC, CURSOR} = pipe[DEPTH-1];

endmodule
